// File: rtl/risc_v_mike_uart_mmio_fifo_if.sv
// -----------------------------------------------------------------------------
// risc_v_mike_uart_mmio_fifo_if
// Data-memory MMIO bus between the core and the FIFO-buffered UART block.
//   data_mmio_addr         byte offset within the block
//   data_mmio_wr_addr_val  write strobe
//   data_mmio_wr_data      write data
//   data_mmio_rd_val       read strobe (qualifies pop side effects)
//   data_mmio_rd_data      combinational read data
// Modports: master (core side), slave (UART block side).
// -----------------------------------------------------------------------------
interface risc_v_mike_uart_mmio_fifo_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] data_mmio_addr;
  logic              data_mmio_wr_addr_val;
  logic [31:0]       data_mmio_wr_data;
  logic              data_mmio_rd_val;
  logic [31:0]       data_mmio_rd_data;

  modport master (
    output data_mmio_addr,
    output data_mmio_wr_addr_val,
    output data_mmio_wr_data,
    output data_mmio_rd_val,
    input  data_mmio_rd_data
  );

  modport slave (
    input  data_mmio_addr,
    input  data_mmio_wr_addr_val,
    input  data_mmio_wr_data,
    input  data_mmio_rd_val,
    output data_mmio_rd_data
  );
endinterface

// File: rtl/risc_v_mike_uart_mmio_fifo.sv
// -----------------------------------------------------------------------------
// risc_v_mike_uart_mmio_fifo
// FIFO-buffered UART MMIO block: TX and RX FIFOs, a TX engine that drains the
// TX FIFO into the UART one byte per handshake, and an RX engine that captures
// each received byte together with its parity status.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mmio            MMIO bus (slave modport of risc_v_mike_uart_mmio_fifo_if)
//   tx_data_ff      byte to UART TX (held until the next send)
//   tx_send_ff      one-cycle send pulse
//   tx_flag_clr_ff  one-cycle TX-done acknowledge
//   rx_flag_clr_ff  RX acknowledge, held until rx_flag falls
//   tx_flag         UART TX done
//   rx_flag         UART RX byte valid
//   rx_data         received byte
//   parity_error    parity status of rx_data
//   irq             interrupt (only when UART_MMIO_IRQ_EN is defined)
//
// Register map: 0x00 TXDATA, 0x04 RXDATA, 0x08 STATUS, 0x0C CLEAR (W1C),
// 0x10 LEVEL, 0x14 IEN (UART_MMIO_IRQ_EN only); other offsets read DEADBEEF.
// Optional feature macro: UART_MMIO_IRQ_EN.
// -----------------------------------------------------------------------------
module risc_v_mike_uart_mmio_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  risc_v_mike_uart_mmio_fifo_if.slave       mmio,
  output logic [DATA_W-1:0]                 tx_data_ff,
  output logic                              tx_send_ff,
  output logic                              tx_flag_clr_ff,
  output logic                              rx_flag_clr_ff,
  input  logic                              tx_flag,
  input  logic                              rx_flag,
  input  logic [DATA_W-1:0]                 rx_data,
  input  logic                              parity_error
`ifdef UART_MMIO_IRQ_EN
  ,
  output logic                              irq
`endif
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned RX_EW = DATA_W + 1;

  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_LEVEL  = ADDR_W'(32'h10);
`ifdef UART_MMIO_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IEN    = ADDR_W'(32'h14);
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT, TX_ACK} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_ACK} rx_state_e;

  tx_state_e               tx_state_q, tx_state_d;
  rx_state_e               rx_state_q, rx_state_d;
  logic [DATA_W-1:0]       tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0]       tx_mem_d [TX_DEPTH];
  logic [RX_EW-1:0]        rx_mem_q [RX_DEPTH];
  logic [RX_EW-1:0]        rx_mem_d [RX_DEPTH];
  logic [TX_AW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RX_AW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TX_CW-1:0]        tx_count_q, tx_count_d;
  logic [RX_CW-1:0]        rx_count_q, rx_count_d;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic                    tx_ovf_q, tx_ovf_d;
  logic                    rx_ovf_q, rx_ovf_d;
  logic                    parity_seen_q, parity_seen_d;
`ifdef UART_MMIO_IRQ_EN
  logic [2:0]              ien_q, ien_d;
  logic                    irq_q, irq_d;
`endif

  logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic wr_tx, wr_clr, rd_rx;
  logic tx_push, tx_pop, rx_capture, rx_push, rx_pop;
  logic [RX_EW-1:0] rx_head;
  logic [31:0] rd_data;
  logic unused_wdata;

  assign unused_wdata = ^mmio.data_mmio_wr_data[31:DATA_W];

  // Full/empty always come from the pre-edge count.
  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign rx_head  = rx_mem_q[rx_rptr_q];

  assign wr_tx  = mmio.data_mmio_wr_addr_val && (mmio.data_mmio_addr == A_TXDATA);
  assign wr_clr = mmio.data_mmio_wr_addr_val && (mmio.data_mmio_addr == A_CLEAR);
  assign rd_rx  = mmio.data_mmio_rd_val && (mmio.data_mmio_addr == A_RXDATA);

  assign tx_push = wr_tx && !tx_full;
  assign rx_push = rx_capture && !rx_full;
  assign rx_pop  = rd_rx && !rx_empty;

  // TX engine
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = TX_SEND;
          // Head is latched on entry so tx_data_ff already shows it during SEND.
          tx_data_d  = tx_mem_q[tx_rptr_q];
        end
      end
      TX_SEND: begin
        tx_pop     = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (tx_flag) tx_state_d = TX_ACK;
      TX_ACK:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX engine: capture happens only on the IDLE->ACK transition, so a held
  // rx_flag yields exactly one byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_capture = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_flag) begin
          rx_capture = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:  if (!rx_flag) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO storage, pointers and counts
  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    rx_mem_d   = rx_mem_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;

    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = mmio.data_mmio_wr_data[DATA_W-1:0];
      tx_wptr_d           = tx_wptr_q + TX_AW'(1);
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + TX_AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
      2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = {parity_error, rx_data};
      rx_wptr_d           = rx_wptr_q + RX_AW'(1);
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + RX_AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
      2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  // Sticky bits: the set term is OR-ed after the clear, so set wins.
  always_comb begin
    tx_ovf_d      = (tx_ovf_q && !(wr_clr && mmio.data_mmio_wr_data[0]))
                    || (wr_tx && tx_full);
    rx_ovf_d      = (rx_ovf_q && !(wr_clr && mmio.data_mmio_wr_data[1]))
                    || (rx_capture && rx_full);
    parity_seen_d = (parity_seen_q && !(wr_clr && mmio.data_mmio_wr_data[2]))
                    || (rx_capture && parity_error);
`ifdef UART_MMIO_IRQ_EN
    ien_d = ien_q;
    if (mmio.data_mmio_wr_addr_val && (mmio.data_mmio_addr == A_IEN))
      ien_d = mmio.data_mmio_wr_data[2:0];
    irq_d = |(ien_q & {tx_ovf_q || rx_ovf_q, tx_empty, !rx_empty});
`endif
  end

  // Read mux
  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    case (mmio.data_mmio_addr)
      A_TXDATA: rd_data = 32'(tx_count_q);
      A_RXDATA: begin
        rd_data = '0;
        if (!rx_empty) begin
          rd_data[31]         = 1'b1;
          rd_data[30]         = rx_head[DATA_W];
          rd_data[DATA_W-1:0] = rx_head[DATA_W-1:0];
        end
      end
      A_STATUS: rd_data = {24'h0, tx_busy, parity_seen_q, tx_ovf_q, rx_ovf_q,
                           rx_empty, rx_full, tx_empty, tx_full};
      A_CLEAR:  rd_data = '0;
      A_LEVEL: begin
        rd_data                = '0;
        rd_data[16 +: RX_CW]   = rx_count_q;
        rd_data[TX_CW-1:0]     = tx_count_q;
      end
`ifdef UART_MMIO_IRQ_EN
      A_IEN:    rd_data = {29'h0, ien_q};
`endif
      default:  rd_data = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_IDLE;
      tx_mem_q      <= '{default: '0};
      rx_mem_q      <= '{default: '0};
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_count_q    <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_count_q    <= '0;
      tx_data_q     <= '0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      parity_seen_q <= 1'b0;
`ifdef UART_MMIO_IRQ_EN
      ien_q         <= '0;
      irq_q         <= 1'b0;
`endif
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_mem_q      <= tx_mem_d;
      rx_mem_q      <= rx_mem_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_count_q    <= tx_count_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_count_q    <= rx_count_d;
      tx_data_q     <= tx_data_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      parity_seen_q <= parity_seen_d;
`ifdef UART_MMIO_IRQ_EN
      ien_q         <= ien_d;
      irq_q         <= irq_d;
`endif
    end
  end

  assign mmio.data_mmio_rd_data = rd_data;
  assign tx_data_ff     = tx_data_q;
  assign tx_send_ff     = (tx_state_q == TX_SEND);
  assign tx_flag_clr_ff = (tx_state_q == TX_ACK);
  assign rx_flag_clr_ff = (rx_state_q == RX_ACK);
`ifdef UART_MMIO_IRQ_EN
  assign irq            = irq_q;
`endif

endmodule
